// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBUS request/response types, burst length encodings and the byte-strobe merge helper.
package cbus_mem_responder_pkg;

    // Encoded as beat count minus one so the FSM can compare the beat counter directly.
    typedef enum logic [3:0] {
        MLEN1  = 4'd0,
        MLEN2  = 4'd1,
        MLEN4  = 4'd3,
        MLEN8  = 4'd7,
        MLEN16 = 4'd15
    } mlen_t;

    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        mlen_t       len;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

    function automatic logic [31:0] strobe_merge(input logic [31:0] old_word,
                                                 input logic [31:0] new_word,
                                                 input logic [3:0]  strobe);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < WORD_BYTES; i++)
            if (strobe[i]) res[8*i +: 8] = new_word[8*i +: 8];
        return res;
    endfunction

endpackage

// File: rtl/cbus_mem_responder_ram.sv
// Word-wide backing store: asynchronous read, synchronous byte-strobed write. Never reset.
module cbus_ram_array
    import cbus_mem_responder_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    strobe,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= strobe_merge(mem[waddr], wdata, strobe);
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cbus_mem_responder.sv
// CBUS memory responder: accepts one burst at a time, waits LATENCY cycles, then streams
// len+1 gap-free beats against a wrapping word store.
module cbus_mem_responder
    import cbus_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  creq,
    output cbus_resp_t cresp
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t      state;
    logic [29:0] word_q;
    logic        is_write_q;
    logic [3:0]  len_q;
    logic [3:0]  beat;
    logic [3:0]  wait_cnt;

    logic [29:0] word_sum;
    logic [AW-1:0] idx;
    logic [31:0] rdata;
    logic        ready;
    logic        we;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            word_q     <= '0;
            is_write_q <= 1'b0;
            len_q      <= '0;
            beat       <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (creq.valid) begin
                        word_q     <= creq.addr[31:2];
                        is_write_q <= creq.is_write;
                        len_q      <= creq.len;
                        beat       <= '0;
                        wait_cnt   <= 4'(LATENCY);
                        state      <= (LATENCY == 0) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (!creq.valid)        state <= IDLE;
                    else if (wait_cnt == 1) state <= BURST;
                end
                BURST: begin
                    // A dropped valid is a protocol violation: abandon the rest of the burst.
                    if (!creq.valid || beat == len_q) begin
                        state <= IDLE;
                        beat  <= '0;
                    end else begin
                        beat  <= beat + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign word_sum = word_q + 30'(beat);
    assign idx      = word_sum[AW-1:0];
    assign ready    = (state == BURST) && creq.valid;
    assign we       = ready && is_write_q && !reset;

    cbus_ram_array #(.WORDS(MEM_WORDS), .AW(AW)) u_ram (
        .clk    (clk),
        .we     (we),
        .waddr  (idx),
        .wdata  (creq.data),
        .strobe (creq.strobe),
        .raddr  (idx),
        .rdata  (rdata)
    );

    always_comb begin
        cresp       = '0;
        cresp.ready = ready;
        cresp.last  = ready && (beat == len_q);
        cresp.data  = (ready && !is_write_q) ? rdata : 32'h0;
    end

    // Transfer size is deliberately ignored; address bits above the store wrap away.
    logic unused;
    assign unused = ^{creq.size, creq.addr[1:0], word_sum};

endmodule
